sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the data word in bits.
REQ-002 Parameter DEPTH, default 256, number of entries; SHALL be a power of two and at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4, occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 4, occupancy at or below which almost_empty asserts.
REQ-005 clk  in  1  single clock; all logic SHALL use its rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_data  in  DATA_WIDTH  write data.
REQ-009 rd_en  in  1  read request.
REQ-010 err_clr  in  1  clears the sticky error flags.
REQ-011 rd_data  out  DATA_WIDTH  read data.
REQ-012 rd_valid  out  1  rd_data holds a newly popped word (see REQ-018).
REQ-013 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 full, half_full, almost_full, empty, half_empty, almost_empty  out  1 each  status flags.
REQ-015 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-016 A write SHALL be accepted iff wr_en && !full; the word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-017 A read SHALL be accepted iff rd_en && !empty; rd_ptr increments modulo DEPTH.
REQ-018 Without FIFO_FWFT_EN, rd_data SHALL present the popped word one cycle after an accepted read, rd_valid SHALL pulse high for that one cycle, and rd_data SHALL hold its value until the next accepted read.
REQ-019 count SHALL update on the edge after acceptance: +1 on a write alone, -1 on a read alone, unchanged when both are accepted in the same cycle.
REQ-020 When full, a simultaneous wr_en and rd_en SHALL accept only the read; count goes to DEPTH-1.
REQ-021 When empty, a simultaneous wr_en and rd_en SHALL accept only the write; count goes to 1.
REQ-022 Flags SHALL be registered and consistent with count in the same cycle.
REQ-023 Flag definitions: full is count==DEPTH; empty is count==0; half_full is count>=DEPTH/2; half_empty is count<DEPTH/2; almost_full is count>=AF_LEVEL; almost_empty is count<=AE_LEVEL.
REQ-024 wr_en while full SHALL drop the word and set overflow; rd_en while empty SHALL set underflow; pointers and count SHALL not change in either case.
REQ-025 overflow and underflow SHALL stay set until err_clr or rst; if err_clr coincides with a new error, the set SHALL win.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of data ordering.

Reset
REQ-027 While rst is high at a clock edge: pointers=0, count=0, empty=1, half_empty=1, almost_empty=1, full=0, half_full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0.
REQ-028 A rst asserted mid-operation SHALL discard all stored data; memory contents need not be cleared.

Configuration
REQ-029 With macro FIFO_FWFT_EN defined, the FIFO SHALL operate first-word-fall-through: rd_data shows the head word whenever !empty, rd_valid equals !empty, an accepted read advances to the next word on the following cycle, and a write into an empty FIFO becomes visible one cycle after acceptance.
REQ-030 Without FIFO_FWFT_EN, the FIFO SHALL use the registered one-cycle read latency of REQ-018; all flag and count behaviour SHALL be identical in both modes.

Structure
REQ-031 Package fifo_pkg SHALL hold the count-width helper function, a ptr_t/count_t typedef scheme, and the default AF/AE margin constants.
REQ-032 Storage SHALL be a sub-module fifo_mem: a simple dual-port RAM with one write port and one read port, DATA_WIDTH x DEPTH, on clk. Pointers, count and flags stay in sync_fifo_flags.
REQ-033 Elaboration SHALL fail if DEPTH is not a power of two or if AE_LEVEL >= AF_LEVEL.

Verification (DEPTH=16, DATA_WIDTH=32, AF_LEVEL=12, AE_LEVEL=4)
REQ-034 Reset, then write 0..15 -> half_full at count 8, almost_full at 12, full at 16; a 17th write sets overflow and count stays 16.
REQ-035 Drain all 16 words -> data 0..15 in order (1-cycle latency, or FWFT if the macro is set), empty at count 0; an extra read sets underflow.
REQ-036 Simultaneous wr/rd at count 5 for 20 cycles -> count stays 5, pointers wrap, data is in order.
REQ-037 Full FIFO with wr_en and rd_en both high -> read accepted, write dropped, count 15, overflow stays 0.
REQ-038 rst pulsed at count 9 -> next cycle count=0, empty=1, all errors 0; err_clr clears a set overflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Width scheme: a pointer is ptr_width(DEPTH) bits and wraps naturally
// because DEPTH is a power of two. An occupancy count is count_width(DEPTH)
// bits so that it can hold DEPTH itself. Each user declares local ptr_t and
// count_t typedefs from these two helpers.
package fifo_pkg;

  // Default distance of the almost-full / almost-empty thresholds from the ends.
  localparam int AF_MARGIN = 4;
  localparam int AE_MARGIN = 4;

  // Registered status flags, all derived from a single occupancy value.
  typedef struct packed {
    logic full;
    logic half_full;
    logic almost_full;
    logic empty;
    logic half_empty;
    logic almost_empty;
  } flags_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic flags_t calc_flags(input int cnt, input int depth,
                                        input int af, input int ae);
    flags_t f;
    f.full         = (cnt == depth);
    f.half_full    = (cnt >= depth / 2);
    f.almost_full  = (cnt >= af);
    f.empty        = (cnt == 0);
    f.half_empty   = (cnt < depth / 2);
    f.almost_empty = (cnt <= ae);
    return f;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one write port, one read port, one clock.
// Latency: write lands at the clock edge; read data is combinational from rd_addr.
// Backpressure: none; the caller guarantees legal addresses and write enables.
//
// Ports: clk; wr_en/wr_addr/wr_data (write port); rd_addr/rd_data (read port).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Contents are deliberately not reset; the pointers in the parent define
  // which entries are live.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy flags and sticky overflow/underflow.
// Latency: write visible in count/flags next cycle; read data one cycle after an accepted read (FWFT: head always shown).
// Backpressure: writes refused while full, reads refused while empty; refused requests raise sticky error flags.
//
// Ports: clk, rst (sync, active-high); wr_en/wr_data; rd_en; err_clr;
//        rd_data/rd_valid; count; full, half_full, almost_full, empty,
//        half_empty, almost_empty; overflow, underflow.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AF_LEVEL   = DEPTH - AF_MARGIN,
  parameter int AE_LEVEL   = AE_MARGIN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic                    err_clr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    half_full,
  output logic                    almost_full,
  output logic                    empty,
  output logic                    half_empty,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] count_t;

  // Illegal configurations stop elaboration.
  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("sync_fifo_flags: AE_LEVEL must be below AF_LEVEL");
  end

  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  count_t                count_q;
  count_t                count_nxt;
  flags_t                flags_q;
  flags_t                flags_nxt;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Acceptance uses the registered flags, so full/empty gate their own side
  // only: a full FIFO still accepts a read, an empty one still accepts a write.
  assign wr_acc = wr_en && !flags_q.full;
  assign rd_acc = rd_en && !flags_q.empty;

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + count_t'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count_q - count_t'(1);
    end
  end

  // Flags are computed from the next count and registered alongside it, so
  // they always agree with the count output in the same cycle.
  assign flags_nxt = calc_flags(int'(count_nxt), DEPTH, AF_LEVEL, AE_LEVEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      flags_q <= calc_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural rollover.
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      count_q <= count_nxt;
      flags_q <= flags_nxt;

      // A full FIFO that is being read in the same cycle is draining; the
      // refused write is treated as a stall, not reported as an overflow.
      // A new error wins over a simultaneous clear.
      if (wr_en && flags_q.full && !rd_en) begin
        ovf_q <= 1'b1;
      end else if (err_clr) begin
        ovf_q <= 1'b0;
      end
      if (rd_en && flags_q.empty) begin
        unf_q <= 1'b1;
      end else if (err_clr) begin
        unf_q <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

`ifdef FIFO_FWFT_EN
  // Head word is always presented; a write into an empty FIFO shows up once
  // the registered empty flag drops, one cycle after acceptance.
  assign rd_valid = !flags_q.empty;
  assign rd_data  = flags_q.empty ? '0 : mem_rd_data;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // Output register captures the popped word and holds it until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem_rd_data;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`endif

  assign count        = count_q;
  assign full         = flags_q.full;
  assign half_full    = flags_q.half_full;
  assign almost_full  = flags_q.almost_full;
  assign empty        = flags_q.empty;
  assign half_empty   = flags_q.half_empty;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: directed boundary sequences plus randomized traffic.
// Reference: a queue-based occupancy model; read data flows through a scoreboard queue.
// The monitor samples on the falling edge, away from the active rising edge.
module tb_sync_fifo_flags;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          err_clr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full, half_full, almost_full, empty, half_empty, almost_empty;
  logic          overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AFL),
    .AE_LEVEL   (AEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .half_full    (half_full),
    .almost_full  (almost_full),
    .empty        (empty),
    .half_empty   (half_empty),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Reference model state (owned by the driver).
  logic [DW-1:0] mq[$];      // words currently stored, head first
  logic [DW-1:0] exp_q[$];   // popped words awaiting appearance on rd_data
  logic [DW-1:0] exp_last;   // value rd_data must hold between pops
  bit            m_ovf;
  bit            m_unf;
  bit            mon_en = 1'b0;
  bit            done   = 1'b0;

  // Counters (owned by the monitor).
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // One clock of stimulus; the model advances from its pre-edge state.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re,
                      input bit ec, input bit rs);
    bit was_full, was_empty;
    wr_en = we; wr_data = wd; rd_en = re; err_clr = ec; rst = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      exp_q.delete();
      exp_last = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (re && !was_empty) begin
        exp_last = mq.pop_front();
        exp_q.push_back(exp_last);
      end
      if (we && !was_full) mq.push_back(wd);
      // Write refused while full is an overflow unless a read drains that cycle.
      if (we && was_full && !re) m_ovf = 1'b1;
      else if (ec)               m_ovf = 1'b0;
      if (re && was_empty)       m_unf = 1'b1;
      else if (ec)               m_unf = 1'b0;
    end
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor / scoreboard.
  int            sz;
  logic [DW-1:0] e;
  always @(negedge clk) begin
    if (mon_en) begin
      sz = mq.size();
      chk("count",        32'(count),        32'(sz));
      chk("full",         32'(full),         32'(sz == DEPTH));
      chk("empty",        32'(empty),        32'(sz == 0));
      chk("half_full",    32'(half_full),    32'(sz >= DEPTH / 2));
      chk("half_empty",   32'(half_empty),   32'(sz < DEPTH / 2));
      chk("almost_full",  32'(almost_full),  32'(sz >= AFL));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= AEL));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
      chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
      if (sz != 0) chk("rd_data_head", rd_data, mq[0]);
`else
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_data_pop", rd_data, e);
      end else begin
        chk("rd_data_hold", rd_data, exp_last);
      end
`endif
      if (done) begin
`ifndef FIFO_FWFT_EN
        chk("no_pending_reads", 32'(exp_q.size()), 32'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  end

  // Run-time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill 0..15 through the thresholds, then a write while full.
    for (int i = 0; i < DEPTH; i++) wr(32'(i));
    wr(32'h99);
    clr();

    // Full with both requests: read wins, write dropped, no overflow.
    step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);

    // Drain the rest in order, then an extra read on empty.
    for (int i = 0; i < DEPTH - 1; i++) rd();
    rd();

    // Steady simultaneous traffic at occupancy 5; pointers wrap.
    for (int i = 0; i < 5; i++) wr($urandom);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);

    // Empty with both requests: write accepted only (after draining).
    for (int i = 0; i < 5; i++) rd();
    step(1'b1, 32'h3a3a, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation at occupancy 9 with underflow still sticky.
    for (int i = 0; i < 8; i++) wr($urandom);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Error set wins over a coinciding clear; plain clear then works.
    for (int i = 0; i < DEPTH; i++) wr($urandom);
    wr($urandom);
    step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    clr();
    for (int i = 0; i < DEPTH; i++) rd();
    rd();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    clr();

    // Randomized traffic in phases biased toward filling, draining, and mixed.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        int wp, rp;
        wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
        rp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
        step($urandom_range(99) < wp, $urandom, $urandom_range(99) < rp,
             $urandom_range(99) < 5, (ph == 3) && ($urandom_range(199) == 0));
      end
    end

    done = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
  end

endmodule
